// File: rtl/fsk_pkg.sv
// Shared constants for the FSK receive path: deframer state codes and frame layout.
package fsk_pkg;

    localparam int   DATA_BITS = 8;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_DATA = 2'd1;
    localparam state_t ST_STOP = 2'd2;

endpackage

// File: rtl/fsk_edge_counter.sv
// Synchronises the FSK input, detects rising edges and counts them over
// free-running windows of BIT_CYCLES clocks, presenting each closed window's count.
module fsk_edge_counter
    import fsk_pkg::*;
#(
    parameter int unsigned BIT_CYCLES = 256,
    parameter int unsigned CNT_W      = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fsk_in,
    input  logic             en,
    output logic [CNT_W-1:0] count_latched,
    output logic             window_done
);

    localparam int unsigned      WIN_W    = $clog2(BIT_CYCLES);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(BIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [2:0]       sync_q, sync_d;
    logic [WIN_W-1:0] win_q, win_d;
    logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [CNT_W-1:0] count_latched_q, count_latched_d;
    logic             window_done_q, window_done_d;
    logic             rise;
    logic             wrap;
    logic [CNT_W-1:0] closing_cnt;

    // The synchroniser keeps running while disabled so edge detect is clean on re-enable.
    always_comb begin
        sync_d          = {sync_q[1:0], fsk_in};
        rise            = sync_q[1] & ~sync_q[2];
        wrap            = (win_q == WIN_LAST);
        closing_cnt     = (rise && (edge_cnt_q != CNT_MAX)) ? edge_cnt_q + 1'b1 : edge_cnt_q;
        win_d           = win_q;
        edge_cnt_d      = edge_cnt_q;
        count_latched_d = count_latched_q;
        window_done_d   = 1'b0;
        if (!en) begin
            win_d      = '0;
            edge_cnt_d = '0;
        end else if (wrap) begin
            // An edge in the last cycle still belongs to the window being closed.
            win_d           = '0;
            edge_cnt_d      = '0;
            count_latched_d = closing_cnt;
            window_done_d   = 1'b1;
        end else begin
            win_d      = win_q + 1'b1;
            edge_cnt_d = closing_cnt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q          <= '0;
            win_q           <= '0;
            edge_cnt_q      <= '0;
            count_latched_q <= '0;
            window_done_q   <= 1'b0;
        end else begin
            sync_q          <= sync_d;
            win_q           <= win_d;
            edge_cnt_q      <= edge_cnt_d;
            count_latched_q <= count_latched_d;
            window_done_q   <= window_done_d;
        end
    end

    assign count_latched = count_latched_q;
    assign window_done   = window_done_q;

endmodule

// File: rtl/fsk_demod.sv
// FSK receiver: slices per-window edge counts into bits and deframes
// start/8 data (LSB first)/stop into bytes with valid, frame-error and carrier status.
module fsk_demod
    import fsk_pkg::*;
#(
    parameter int unsigned BIT_CYCLES  = 256,
    parameter int unsigned CNT_W       = 9,
    parameter int unsigned THRESH      = 24,
    parameter int unsigned MIN_EDGES   = 4,
    parameter int unsigned HIGH_IS_ONE = 0
) (
    input  logic       RX_CLK,
    input  logic       RESET,
    input  logic       FSK_IN,
    input  logic       RX_EN,
    output logic       BIT_OUT,
    output logic       BIT_STROBE,
    output logic       CARRIER_OK,
    output logic [7:0] RX_BYTE,
    output logic       RX_VALID,
    output logic       FRAME_ERR
);

    logic [CNT_W-1:0] count_latched;
    logic             window_done;
    logic [31:0]      count_ext;
    logic             hi;

    logic       bit_out_q, bit_out_d;
    logic       bit_strobe_q, bit_strobe_d;
    logic       carrier_ok_q, carrier_ok_d;
    logic [7:0] rx_byte_q, rx_byte_d;
    logic       rx_valid_q, rx_valid_d;
    logic       frame_err_q, frame_err_d;
    state_t     state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] shreg_q, shreg_d;

    fsk_edge_counter #(
        .BIT_CYCLES(BIT_CYCLES),
        .CNT_W     (CNT_W)
    ) u_edge_counter (
        .clk          (RX_CLK),
        .rst          (RESET),
        .fsk_in       (FSK_IN),
        .en           (RX_EN),
        .count_latched(count_latched),
        .window_done  (window_done)
    );

    always_comb begin
        count_ext    = 32'(count_latched);
        hi           = (count_ext >= THRESH);
        bit_strobe_d = window_done & RX_EN;
        bit_out_d    = bit_out_q;
        carrier_ok_d = carrier_ok_q;
        if (bit_strobe_d) begin
            bit_out_d    = (HIGH_IS_ONE != 0) ? hi : ~hi;
            carrier_ok_d = (count_ext >= MIN_EDGES);
        end
    end

    // The deframer consumes the bit registered on the previous strobe, so pulses trail it by one cycle.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        shreg_d     = shreg_q;
        rx_byte_d   = rx_byte_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        if (!RX_EN) begin
            state_d = ST_IDLE;
            idx_d   = '0;
        end else if (bit_strobe_q) begin
            case (state_q)
                ST_IDLE: begin
                    if ((bit_out_q == START_BIT) && carrier_ok_q) begin
                        state_d = ST_DATA;
                        idx_d   = '0;
                    end
                end
                ST_DATA: begin
                    if (!carrier_ok_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        shreg_d[idx_q] = bit_out_q;
                        if (idx_q == 3'(DATA_BITS - 1)) begin
                            state_d = ST_STOP;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end
                end
                ST_STOP: begin
                    state_d = ST_IDLE;
                    if (carrier_ok_q) begin
                        if (bit_out_q == STOP_BIT) begin
                            rx_byte_d  = shreg_q;
                            rx_valid_d = 1'b1;
                        end else begin
                            frame_err_d = 1'b1;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge RX_CLK or posedge RESET) begin
        if (RESET) begin
            bit_out_q    <= 1'b0;
            bit_strobe_q <= 1'b0;
            carrier_ok_q <= 1'b0;
            rx_byte_q    <= 8'h00;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            shreg_q      <= '0;
        end else begin
            bit_out_q    <= bit_out_d;
            bit_strobe_q <= bit_strobe_d;
            carrier_ok_q <= carrier_ok_d;
            rx_byte_q    <= rx_byte_d;
            rx_valid_q   <= rx_valid_d;
            frame_err_q  <= frame_err_d;
            state_q      <= state_d;
            idx_q        <= idx_d;
            shreg_q      <= shreg_d;
        end
    end

    assign BIT_OUT    = bit_out_q;
    assign BIT_STROBE = bit_strobe_q;
    assign CARRIER_OK = carrier_ok_q;
    assign RX_BYTE    = rx_byte_q;
    assign RX_VALID   = rx_valid_q;
    assign FRAME_ERR  = frame_err_q;

endmodule

// File: tb/tb_fsk_demod.sv
// Bench for fsk_demod: window-aligned FSK stimulus, a behavioural receiver model
// compared every cycle, and literal expectations for the key scenarios.
module tb_fsk_demod;

    localparam int BC      = 64;
    localparam int CW      = 4;
    localparam int TH      = 12;
    localparam int ME      = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic       RX_CLK = 1'b0;
    logic       RESET  = 1'b1;
    logic       FSK_IN = 1'b0;
    logic       RX_EN  = 1'b1;
    logic       BIT_OUT, BIT_STROBE, CARRIER_OK, RX_VALID, FRAME_ERR;
    logic [7:0] RX_BYTE;

    int checks = 0;
    int errors = 0;
    int print_budget = 20;
    int off = 0;
    int valid_seen = 0, err_seen = 0, loss_seen = 0;
    logic last_bit = 1'b0, last_carrier = 1'b0;

    // behavioural model state (values after the most recent clock edge)
    bit       samples[$] = '{0, 0, 0};
    bit       m_rise;
    int       m_win_pos = 0, m_count = 0, m_closed_count = 0;
    bit       m_close_pending = 0, m_strobe = 0, m_bit = 0, m_carrier = 0;
    bit       m_valid = 0, m_err = 0, s_bit = 0, s_car = 0, s_strobe = 0, s_close = 0;
    bit [7:0] m_byte = 8'h00, m_shift = 8'h00;
    int       m_phase = -1;

    always #5 RX_CLK = ~RX_CLK;

    fsk_demod #(
        .BIT_CYCLES(BC), .CNT_W(CW), .THRESH(TH), .MIN_EDGES(ME), .HIGH_IS_ONE(0)
    ) dut (
        .RX_CLK(RX_CLK), .RESET(RESET), .FSK_IN(FSK_IN), .RX_EN(RX_EN),
        .BIT_OUT(BIT_OUT), .BIT_STROBE(BIT_STROBE), .CARRIER_OK(CARRIER_OK),
        .RX_BYTE(RX_BYTE), .RX_VALID(RX_VALID), .FRAME_ERR(FRAME_ERR)
    );

    function automatic logic wave(input int period, input int rises, input int o);
        return ((o % period) >= (period / 2)) && ((o / period) < rises);
    endfunction

    task automatic model_deframe(input bit b, input bit c);
        if (m_phase < 0) begin
            if (b == 1'b0 && c) m_phase = 0;
        end else if (!c) begin
            m_phase = -1;
        end else if (m_phase < 8) begin
            m_shift[m_phase] = b;
            m_phase++;
        end else begin
            if (b) begin
                m_byte  = m_shift;
                m_valid = 1;
            end else begin
                m_err = 1;
            end
            m_phase = -1;
        end
    endtask

    // Model: a rise seen at the input is counted two clocks later (synchroniser delay)
    // in whatever window is then open; decisions and frame pulses follow one clock apart.
    always @(posedge RX_CLK) begin
        if (RESET) begin
            samples = '{0, 0, 0};
            m_win_pos = 0; m_count = 0; m_closed_count = 0; m_close_pending = 0;
            m_strobe = 0; m_bit = 0; m_carrier = 0; m_valid = 0; m_err = 0;
            m_byte = 8'h00; m_shift = 8'h00; m_phase = -1;
        end else begin
            samples.push_back(FSK_IN);
            if (samples.size() > 8) samples.delete(0);
            m_rise   = samples[$-2] && !samples[$-3];
            s_strobe = m_strobe; s_bit = m_bit; s_car = m_carrier; s_close = m_close_pending;
            if (!RX_EN) begin
                m_win_pos = 0; m_count = 0; m_close_pending = 0;
                m_strobe = 0; m_valid = 0; m_err = 0; m_phase = -1;
            end else begin
                m_valid = 0;
                m_err   = 0;
                if (s_strobe) model_deframe(s_bit, s_car);
                m_strobe = s_close;
                if (s_close) begin
                    m_bit     = !(m_closed_count >= TH);
                    m_carrier = (m_closed_count >= ME);
                end
                if (m_rise && m_count < CNT_MAX) m_count++;
                if (m_win_pos == BC - 1) begin
                    m_closed_count  = m_count;
                    m_close_pending = 1;
                    m_count   = 0;
                    m_win_pos = 0;
                end else begin
                    m_close_pending = 0;
                    m_win_pos++;
                end
            end
        end
    end

    // Per-cycle comparison against the model, plus pulse monitors for literal checks.
    always @(negedge RX_CLK) begin
        logic [12:0] act, exp_v;
        act   = {BIT_OUT, BIT_STROBE, CARRIER_OK, RX_BYTE, RX_VALID, FRAME_ERR};
        exp_v = RESET ? 13'd0 : {m_bit, m_strobe, m_carrier, m_byte, m_valid, m_err};
        checks++;
        if (act !== exp_v) begin
            errors++;
            if (print_budget > 0) begin
                print_budget--;
                $display("[TB] FAIL outputs t=%0t actual=%b expected=%b", $time, act, exp_v);
            end
        end
        if (RX_VALID) valid_seen++;
        if (FRAME_ERR) err_seen++;
        if (BIT_STROBE) begin
            last_bit     = BIT_OUT;
            last_carrier = CARRIER_OK;
            if (!CARRIER_OK) loss_seen++;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Drives FSK_IN up to the end of the current bit window.
    task automatic applyStimulus(input int period, input int rises);
        do begin
            FSK_IN = wave(period, rises, off);
            @(negedge RX_CLK);
            off = (off + 1) % BC;
        end while (off != 0);
    endtask

    task automatic sendFrame(input logic [7:0] data, input logic stop_bit, input int loss_win);
        logic b;
        for (int w = 0; w < 10; w++) begin
            b = (w == 0) ? 1'b0 : (w == 9) ? stop_bit : data[w-1];
            if (w == loss_win) applyStimulus(4, 0);
            else applyStimulus(b ? 8 : 4, 64);
        end
    endtask

    initial begin
        int v0, e0, l0, cyc, p;
        logic [7:0] rb;
        $display("[TB] start");
        repeat (3) @(negedge RX_CLK);
        RESET = 1'b0;
        off = 2;
        applyStimulus(8, 64);

        // reset mid-window
        for (int i = 0; i < 30; i++) begin
            FSK_IN = wave(4, 64, off);
            @(negedge RX_CLK);
            off = (off + 1) % BC;
        end
        #2 RESET = 1'b1;
        #1 checkOutput("reset_async", {19'd0, BIT_OUT, BIT_STROBE, CARRIER_OK, RX_BYTE, RX_VALID, FRAME_ERR}, 32'd0);
        FSK_IN = 1'b0;
        repeat (3) @(negedge RX_CLK);
        RESET = 1'b0;
        off = 2;
        cyc = 0;
        for (int i = 1; i <= 200 && cyc == 0; i++) begin
            FSK_IN = wave(8, 64, off);
            @(negedge RX_CLK);
            off = (off + 1) % BC;
            if (BIT_STROBE) cyc = i;
        end
        checkOutput("first_strobe_latency", cyc, 65);
        checkOutput("first_bit_mark", BIT_OUT, 1);
        applyStimulus(8, 64);
        applyStimulus(8, 64);

        // good frame A5
        v0 = valid_seen; e0 = err_seen;
        sendFrame(8'hA5, 1'b1, -1);
        applyStimulus(8, 64); applyStimulus(8, 64);
        checkOutput("a5_byte", RX_BYTE, 8'hA5);
        checkOutput("a5_valid_count", valid_seen - v0, 1);
        checkOutput("a5_err_count", err_seen - e0, 0);

        // bad stop bit
        v0 = valid_seen; e0 = err_seen;
        sendFrame(8'h3C, 1'b0, -1);
        applyStimulus(8, 64); applyStimulus(8, 64);
        checkOutput("badstop_err_count", err_seen - e0, 1);
        checkOutput("badstop_valid_count", valid_seen - v0, 0);
        checkOutput("badstop_byte_held", RX_BYTE, 8'hA5);

        // carrier loss in window 4, then a clean 5A
        v0 = valid_seen; e0 = err_seen; l0 = loss_seen;
        sendFrame(8'hF3, 1'b1, 4);
        applyStimulus(8, 64); applyStimulus(8, 64);
        checkOutput("loss_strobe_count", loss_seen - l0, 1);
        checkOutput("loss_pulse_count", (valid_seen - v0) + (err_seen - e0), 0);
        sendFrame(8'h5A, 1'b1, -1);
        applyStimulus(8, 64); applyStimulus(8, 64);
        checkOutput("after_loss_byte", RX_BYTE, 8'h5A);
        checkOutput("after_loss_valid", valid_seen - v0, 1);

        // threshold boundaries
        v0 = valid_seen; e0 = err_seen;
        applyStimulus(4, 12);
        applyStimulus(4, 11);
        checkOutput("thresh12_bit", last_bit, 0);
        checkOutput("thresh12_carrier", last_carrier, 1);
        applyStimulus(4, 3);
        checkOutput("thresh11_bit", last_bit, 1);
        checkOutput("thresh11_carrier", last_carrier, 1);
        applyStimulus(8, 64);
        checkOutput("edges3_carrier", last_carrier, 0);
        repeat (10) applyStimulus(8, 64);
        checkOutput("thresh_pulse_count", (valid_seen - v0) + (err_seen - e0), 0);

        // saturation, then RX_EN dropped mid-frame
        applyStimulus(2, 64);
        applyStimulus(8, 64);
        checkOutput("sat_bit", last_bit, 0);
        checkOutput("sat_carrier", last_carrier, 1);
        applyStimulus(8, 64); applyStimulus(8, 64);
        v0 = valid_seen;
        RX_EN = 1'b0; FSK_IN = 1'b0;
        repeat (10) @(negedge RX_CLK);
        checkOutput("disabled_bit_held", BIT_OUT, 1);
        RX_EN = 1'b1;
        off = 2;
        repeat (12) applyStimulus(8, 64);
        checkOutput("rxen_drop_no_valid", valid_seen - v0, 0);
        sendFrame(8'hC3, 1'b1, -1);
        applyStimulus(8, 64); applyStimulus(8, 64);
        checkOutput("reenable_byte", RX_BYTE, 8'hC3);
        checkOutput("reenable_valid", valid_seen - v0, 1);

        // random noise window followed by a random byte
        for (int r = 0; r < 6; r++) begin
            rb = 8'($urandom);
            case ($urandom_range(0, 2))
                0: p = 2;
                1: p = 4;
                default: p = 8;
            endcase
            applyStimulus(p, $urandom_range(0, 20));
            repeat (11) applyStimulus(8, 64);
            sendFrame(rb, 1'b1, -1);
            applyStimulus(8, 64); applyStimulus(8, 64);
            checkOutput("random_byte", RX_BYTE, rb);
        end

        repeat (5) @(negedge RX_CLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
